// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and the key event payload
// used by the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_PAUSE     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT    = 8'h12;
  localparam logic [7:0] SC_RSHIFT    = 8'h59;
  localparam logic [7:0] SC_CAPS      = 8'h58;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_BKSP      = 8'h66;
  localparam logic [7:0] SC_SPACE     = 8'h29;
  localparam logic [7:0] SC_PAUSE_KEY = 8'h77;
  localparam logic [2:0] PAUSE_LEN    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
  } key_evt_t;

  // Keyboard status/ack bytes that carry no key information when seen idle
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational scan code set 2 to ASCII translation with Shift/Caps handling.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii_c
);

  logic [7:0] w_letter;
  logic [7:0] w_digit;
  logic [7:0] w_digit_sh;

  // Lower-case letters; zero means "not a letter"
  always_comb begin
    w_letter = 8'h00;
    case (i_code)
      8'h1C: w_letter = 8'h61;  8'h32: w_letter = 8'h62;  8'h21: w_letter = 8'h63;
      8'h23: w_letter = 8'h64;  8'h24: w_letter = 8'h65;  8'h2B: w_letter = 8'h66;
      8'h34: w_letter = 8'h67;  8'h33: w_letter = 8'h68;  8'h43: w_letter = 8'h69;
      8'h3B: w_letter = 8'h6A;  8'h42: w_letter = 8'h6B;  8'h4B: w_letter = 8'h6C;
      8'h3A: w_letter = 8'h6D;  8'h31: w_letter = 8'h6E;  8'h44: w_letter = 8'h6F;
      8'h4D: w_letter = 8'h70;  8'h15: w_letter = 8'h71;  8'h2D: w_letter = 8'h72;
      8'h1B: w_letter = 8'h73;  8'h2C: w_letter = 8'h74;  8'h3C: w_letter = 8'h75;
      8'h2A: w_letter = 8'h76;  8'h1D: w_letter = 8'h77;  8'h22: w_letter = 8'h78;
      8'h35: w_letter = 8'h79;  8'h1A: w_letter = 8'h7A;
      default: w_letter = 8'h00;
    endcase
  end

  // Digit row: plain and shifted symbols
  always_comb begin
    w_digit    = 8'h00;
    w_digit_sh = 8'h00;
    case (i_code)
      8'h45: begin w_digit = 8'h30; w_digit_sh = 8'h29; end
      8'h16: begin w_digit = 8'h31; w_digit_sh = 8'h21; end
      8'h1E: begin w_digit = 8'h32; w_digit_sh = 8'h40; end
      8'h26: begin w_digit = 8'h33; w_digit_sh = 8'h23; end
      8'h25: begin w_digit = 8'h34; w_digit_sh = 8'h24; end
      8'h2E: begin w_digit = 8'h35; w_digit_sh = 8'h25; end
      8'h36: begin w_digit = 8'h36; w_digit_sh = 8'h5E; end
      8'h3D: begin w_digit = 8'h37; w_digit_sh = 8'h26; end
      8'h3E: begin w_digit = 8'h38; w_digit_sh = 8'h2A; end
      8'h46: begin w_digit = 8'h39; w_digit_sh = 8'h28; end
      default: begin w_digit = 8'h00; w_digit_sh = 8'h00; end
    endcase
  end

  always_comb begin
    o_ascii_c = 8'h00;
    if (!i_ext) begin
      if (w_letter != 8'h00) begin
        o_ascii_c = (i_shift ^ i_caps) ? (w_letter - 8'h20) : w_letter;
      end else if (w_digit != 8'h00) begin
        o_ascii_c = i_shift ? w_digit_sh : w_digit;
      end else begin
        case (i_code)
          SC_SPACE: o_ascii_c = 8'h20;
          SC_ENTER: o_ascii_c = 8'h0D;
          SC_BKSP:  o_ascii_c = 8'h08;
          default:  o_ascii_c = 8'h00;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan code set 2 decoder: prefix FSM, Shift/Caps tracking and an event FIFO
// with ready/valid output.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DP_size    = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [DP_size-1:0] RX_DATA,
  input  logic               DATA_VALID,
  input  logic               EVT_READY,
  output logic               EVT_VALID,
  output logic [DP_size-1:0] KEY_CODE,
  output logic               KEY_EXT,
  output logic               KEY_REL,
  output logic [7:0]         KEY_ASCII,
  output logic               SHIFT_ON,
  output logic               CAPS_ON,
  output logic               OVERFLOW
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  state_t     r_state, w_state_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic       r_lshift, r_rshift, r_caps, r_ovf;
  logic       w_lshift_n, w_rshift_n, w_caps_n;
  logic [7:0] w_byte, w_code, w_ascii;
  logic       w_emit, w_ext, w_rel;
  key_evt_t   w_evt, w_head;
  key_evt_t   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_count;
  logic       w_valid, w_full, w_pop, w_push, w_drop;

  assign w_byte = 8'(RX_DATA);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Prefix decoding; an emitting byte returns the FSM to IDLE
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_emit    = 1'b0;
    w_ext     = 1'b0;
    w_rel     = 1'b0;
    w_code    = w_byte;
    if (DATA_VALID) begin
      if (r_state == ST_PAUSE) begin
        w_cnt_n = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_emit    = 1'b1;
          w_code    = SC_PAUSE_KEY;
          w_ext     = 1'b1;
          w_cnt_n   = 3'd0;
          w_state_n = ST_IDLE;
        end
      end else if (w_byte == SC_PAUSE) begin
        w_state_n = ST_PAUSE;
        w_cnt_n   = PAUSE_LEN;
      end else if (w_byte == SC_EXT) begin
        w_state_n = ST_EXT;
      end else if (w_byte == SC_BRK && r_state == ST_IDLE) begin
        w_state_n = ST_BRK;
      end else if (w_byte == SC_BRK && r_state == ST_EXT) begin
        w_state_n = ST_EXT_BRK;
      end else if (!(r_state == ST_IDLE && is_ignored(w_byte))) begin
        w_emit    = 1'b1;
        w_ext     = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
        w_rel     = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
        w_state_n = ST_IDLE;
      end
    end
  end

  // Modifier state as seen by the ASCII lookup of the same event
  always_comb begin
    w_lshift_n = r_lshift;
    w_rshift_n = r_rshift;
    w_caps_n   = r_caps;
    if (w_emit && !w_ext) begin
      if (w_code == SC_LSHIFT) w_lshift_n = !w_rel;
      if (w_code == SC_RSHIFT) w_rshift_n = !w_rel;
      if (w_code == SC_CAPS && !w_rel) w_caps_n = !r_caps;
    end
  end

  ps2_ascii_lut u_lut (
    .i_code    (w_code),
    .i_ext     (w_ext),
    .i_shift   (w_lshift_n | w_rshift_n),
    .i_caps    (w_caps_n),
    .o_ascii_c (w_ascii)
  );

  assign w_evt   = {w_code, w_ext, w_rel, w_ascii};
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_valid = (r_wr_ptr != r_rd_ptr);
  assign w_full  = (w_count == PW'(FIFO_DEPTH));
  assign w_pop   = w_valid && EVT_READY;
  assign w_push  = w_emit && (!w_full || w_pop);
  assign w_drop  = w_emit && w_full && !w_pop;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_lshift <= w_lshift_n;
      r_rshift <= w_rshift_n;
      r_caps   <= w_caps_n;
      if (w_drop) r_ovf    <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_evt;
  end

  // Head fields forced to zero while empty so reset leaves every output at 0
  assign w_head    = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign EVT_VALID = w_valid;
  assign KEY_CODE  = DP_size'(w_head.code);
  assign KEY_EXT   = w_head.ext;
  assign KEY_REL   = w_head.rel;
  assign KEY_ASCII = w_head.ascii;
  assign SHIFT_ON  = r_lshift | r_rshift;
  assign CAPS_ON   = r_caps;
  assign OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: byte-vector table with expected events queued on a
// scoreboard, plus reset, overflow and full-FIFO push/pop sequences.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] RX_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       EVT_READY = 1'b1;
  logic       EVT_VALID;
  logic [7:0] KEY_CODE;
  logic       KEY_EXT, KEY_REL;
  logic [7:0] KEY_ASCII;
  logic       SHIFT_ON, CAPS_ON, OVERFLOW;

  ps2_key_decoder #(.DP_size(8), .FIFO_DEPTH(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RX_DATA(RX_DATA), .DATA_VALID(DATA_VALID),
    .EVT_READY(EVT_READY), .EVT_VALID(EVT_VALID), .KEY_CODE(KEY_CODE),
    .KEY_EXT(KEY_EXT), .KEY_REL(KEY_REL), .KEY_ASCII(KEY_ASCII),
    .SHIFT_ON(SHIFT_ON), .CAPS_ON(CAPS_ON), .OVERFLOW(OVERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [7:0] b;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] asc;
    logic       sh;
    logic       cp;
  } vec_t;

  vec_t     vecs[$];
  key_evt_t exp_q[$];
  key_evt_t mon_e;
  logic     mon_en = 1'b0;
  int       checks = 0;
  int       failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted head event is checked against the queue
  always begin
    @(negedge CLOCK);
    #1;
    if (mon_en && EVT_VALID === 1'b1 && EVT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got %h%h%h%h expected none",
                 KEY_CODE, KEY_EXT, KEY_REL, KEY_ASCII);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event", {14'd0, KEY_CODE, KEY_EXT, KEY_REL, KEY_ASCII}, {14'd0, mon_e});
      end
    end
  end

  task automatic add(input logic [7:0] b, input logic ev, input logic [7:0] code,
                     input logic ext, input logic rel, input logic [7:0] asc,
                     input logic sh, input logic cp);
    vecs.push_back({b, ev, code, ext, rel, asc, sh, cp});
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic rel,
                            input logic [7:0] asc);
    exp_q.push_back({code, ext, rel, asc});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK);
    RX_DATA    = b;
    DATA_VALID = 1'b1;
    @(negedge CLOCK);
    DATA_VALID = 1'b0;
    RX_DATA    = 8'h00;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d events outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(EVT_VALID), 32'd0);
    chk({tag, "_code"},  32'(KEY_CODE),  32'd0);
    chk({tag, "_ext"},   32'(KEY_EXT),   32'd0);
    chk({tag, "_rel"},   32'(KEY_REL),   32'd0);
    chk({tag, "_ascii"}, 32'(KEY_ASCII), 32'd0);
    chk({tag, "_shift"}, 32'(SHIFT_ON),  32'd0);
    chk({tag, "_caps"},  32'(CAPS_ON),   32'd0);
    chk({tag, "_ovf"},   32'(OVERFLOW),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] ovf_codes [9];
  logic [7:0] ovf_ascii [9];

  initial begin
    // byte, event?, code, ext, rel, ascii, SHIFT_ON after, CAPS_ON after
    add(8'h1C,1,8'h1C,0,0,8'h61,0,0); add(8'hF0,0,0,0,0,0,0,0); add(8'h1C,1,8'h1C,0,1,8'h61,0,0);
    add(8'h12,1,8'h12,0,0,8'h00,1,0); add(8'h1C,1,8'h1C,0,0,8'h41,1,0);
    add(8'hF0,0,0,0,0,0,1,0);         add(8'h12,1,8'h12,0,1,8'h00,0,0);
    add(8'h58,1,8'h58,0,0,8'h00,0,1); add(8'hF0,0,0,0,0,0,0,1); add(8'h58,1,8'h58,0,1,8'h00,0,1);
    add(8'h1C,1,8'h1C,0,0,8'h41,0,1); add(8'hAA,0,0,0,0,0,0,1); add(8'hFA,0,0,0,0,0,0,1);
    add(8'hE0,0,0,0,0,0,0,1);         add(8'h75,1,8'h75,1,0,8'h00,0,1);
    add(8'hE0,0,0,0,0,0,0,1); add(8'hF0,0,0,0,0,0,0,1); add(8'h75,1,8'h75,1,1,8'h00,0,1);
    add(8'hE1,0,0,0,0,0,0,1); add(8'h14,0,0,0,0,0,0,1); add(8'h77,0,0,0,0,0,0,1);
    add(8'hE1,0,0,0,0,0,0,1); add(8'hF0,0,0,0,0,0,0,1); add(8'h14,0,0,0,0,0,0,1);
    add(8'hF0,0,0,0,0,0,0,1); add(8'h77,1,8'h77,1,0,8'h00,0,1);
    add(8'h1C,1,8'h1C,0,0,8'h41,0,1); add(8'h16,1,8'h16,0,0,8'h31,0,1);
    add(8'h59,1,8'h59,0,0,8'h00,1,1); add(8'h16,1,8'h16,0,0,8'h21,1,1);
    add(8'h1C,1,8'h1C,0,0,8'h61,1,1); add(8'hF0,0,0,0,0,0,1,1); add(8'h59,1,8'h59,0,1,8'h00,0,1);
    add(8'h58,1,8'h58,0,0,8'h00,0,0); add(8'hF0,0,0,0,0,0,0,0); add(8'h58,1,8'h58,0,1,8'h00,0,0);
    add(8'h29,1,8'h29,0,0,8'h20,0,0); add(8'h5A,1,8'h5A,0,0,8'h0D,0,0);
    add(8'h66,1,8'h66,0,0,8'h08,0,0); add(8'h45,1,8'h45,0,0,8'h30,0,0);
    add(8'h4D,1,8'h4D,0,0,8'h70,0,0); add(8'hE0,0,0,0,0,0,0,0); add(8'h5A,1,8'h5A,1,0,8'h00,0,0);

    ovf_codes = '{8'h15, 8'h1A, 8'h1C, 8'h1D, 8'h21, 8'h22, 8'h23, 8'h24, 8'h2B};
    ovf_ascii = '{8'h71, 8'h7A, 8'h61, 8'h77, 8'h63, 8'h78, 8'h64, 8'h65, 8'h66};

    repeat (3) @(negedge CLOCK);
    chk_zero("reset");
    RESET  = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].ev) expect_evt(vecs[i].code, vecs[i].ext, vecs[i].rel, vecs[i].asc);
      send(vecs[i].b);
      chk($sformatf("shift_%0d", i), 32'(SHIFT_ON), 32'(vecs[i].sh));
      chk($sformatf("caps_%0d", i),  32'(CAPS_ON),  32'(vecs[i].cp));
    end
    drain();
    chk("table_empty", 32'(EVT_VALID), 32'd0);

    // Reset mid-prefix with queued events and held modifiers
    EVT_READY = 1'b0;
    send(8'h12); send(8'h58); send(8'h1C); send(8'hE0);
    chk("pre_reset_valid", 32'(EVT_VALID), 32'd1);
    RESET = 1'b1;
    @(negedge CLOCK);
    chk_zero("midreset");
    @(negedge CLOCK);
    RESET = 1'b0;
    EVT_READY = 1'b1;
    expect_evt(8'h1C, 0, 0, 8'h61);
    send(8'h1C);
    drain();

    // Overflow: nine makes into an eight-deep FIFO with no consumer
    do_reset();
    EVT_READY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_evt(ovf_codes[i], 0, 0, ovf_ascii[i]);
      send(ovf_codes[i]);
    end
    chk("ovf_at_full", 32'(OVERFLOW), 32'd0);
    send(ovf_codes[8]);
    chk("ovf_after_drop", 32'(OVERFLOW), 32'd1);
    chk("ovf_valid", 32'(EVT_VALID), 32'd1);
    EVT_READY = 1'b1;
    drain();
    chk("ovf_empty", 32'(EVT_VALID), 32'd0);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Full FIFO with push and pop in the same cycle
    do_reset();
    EVT_READY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_evt(ovf_codes[i], 0, 0, ovf_ascii[i]);
      send(ovf_codes[i]);
    end
    @(negedge CLOCK);
    expect_evt(ovf_codes[8], 0, 0, ovf_ascii[8]);
    RX_DATA    = ovf_codes[8];
    DATA_VALID = 1'b1;
    EVT_READY  = 1'b1;
    @(negedge CLOCK);
    DATA_VALID = 1'b0;
    drain();
    chk("pushpop_no_ovf", 32'(OVERFLOW), 32'd0);
    chk("pushpop_empty", 32'(EVT_VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
